// File: rtl/frame_scan_out.sv
// Display scan-out: raster timing, frame-buffer read strobes and
// output re-timing so de, syncs and pixel data leave aligned.
module frame_scan_out #(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 4,
    parameter int H_FP       = 1,
    parameter int H_SYNC     = 2,
    parameter int H_BP       = 1,
    parameter int V_ACTIVE   = 2,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 1,
    parameter int V_BP       = 1,
    parameter int RD_LATENCY = 1,
    parameter bit SYNC_POL   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_rdy,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] pix_out,
    output logic                  de,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW  = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW  = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DLY = RD_LATENCY + 1;
    localparam logic SYNC_IDLE = ~SYNC_POL;

    typedef enum logic {
        S_WAIT,
        S_RUN
    } state_t;

    state_t                  state_q;
    logic [HW-1:0]           h_cnt_q;
    logic [VW-1:0]           v_cnt_q;
    logic [DLY-1:0]          de_pipe_q, de_pipe_d;
    logic [DLY-1:0]          hs_pipe_q, hs_pipe_d;
    logic [DLY-1:0]          vs_pipe_q, vs_pipe_d;
    logic [DATA_WIDTH-1:0]   pix_q, pix_d;

    logic run, h_last, v_last, h_act, v_act, hs_raw, vs_raw;

    assign run    = (state_q == S_RUN);
    assign h_last = (h_cnt_q == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt_q == VW'(V_TOTAL - 1));
    assign h_act  = (int'(h_cnt_q) < H_ACTIVE);
    assign v_act  = (int'(v_cnt_q) < V_ACTIVE);
    assign hs_raw = run
                 && (int'(h_cnt_q) >= H_ACTIVE + H_FP)
                 && (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
    assign vs_raw = run
                 && (int'(v_cnt_q) >= V_ACTIVE + V_FP)
                 && (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);

    assign rd_en      = run && h_act && v_act;
    assign frame_done = rd_en
                     && (int'(h_cnt_q) == H_ACTIVE - 1)
                     && (int'(v_cnt_q) == V_ACTIVE - 1);

    // Frame sequencing: leave WAIT on frame_rdy, only stop at a frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                    if (frame_rdy) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (h_last) begin
                        h_cnt_q <= '0;
                        if (v_last) begin
                            v_cnt_q <= '0;
                            if (!frame_rdy) state_q <= S_WAIT;
                        end else begin
                            v_cnt_q <= v_cnt_q + 1'b1;
                        end
                    end else begin
                        h_cnt_q <= h_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Delay strobe and syncs to line up with the buffer's returned pixel
    always_comb begin
        de_pipe_d = {de_pipe_q[DLY-2:0], rd_en};
        hs_pipe_d = {hs_pipe_q[DLY-2:0], hs_raw ^ SYNC_IDLE};
        vs_pipe_d = {vs_pipe_q[DLY-2:0], vs_raw ^ SYNC_IDLE};
        pix_d     = de_pipe_q[RD_LATENCY-1] ? rd_data : '0;
    end

    // Output pipeline registers; reset clears any in-flight pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            de_pipe_q <= '0;
            hs_pipe_q <= {DLY{SYNC_IDLE}};
            vs_pipe_q <= {DLY{SYNC_IDLE}};
            pix_q     <= '0;
        end else begin
            de_pipe_q <= de_pipe_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            pix_q     <= pix_d;
        end
    end

    assign de      = de_pipe_q[DLY-1];
    assign hsync   = hs_pipe_q[DLY-1];
    assign vsync   = vs_pipe_q[DLY-1];
    assign pix_out = pix_q;

endmodule

// File: tb/tb_frame_scan_out.sv
// Scoreboard bench for frame_scan_out: a raster-position model predicts
// every output each cycle; a monitor pops and compares at negedge.
module tb_frame_scan_out;

    localparam int DW   = 24;
    localparam int L    = 1;
    localparam int D    = L + 1;
    localparam int HA   = 4;
    localparam int HFP  = 1;
    localparam int HS   = 2;
    localparam int HBP  = 1;
    localparam int VA   = 2;
    localparam int VFP  = 1;
    localparam int VS   = 1;
    localparam int VBP  = 1;
    localparam int HT   = HA + HFP + HS + HBP;
    localparam int VT   = VA + VFP + VS + VBP;
    localparam int FT   = HT * VT;
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_rdy = 1'b0;
    logic [DW-1:0] rd_data = '0;

    logic          rd_en1, de1, hs1, vs1, fd1;
    logic [DW-1:0] pix1;
    logic          rd_en0, de0, hs0, vs0, fd0;
    logic [DW-1:0] pix0;

    frame_scan_out #(.DATA_WIDTH(DW), .RD_LATENCY(L), .SYNC_POL(1'b1)) u_pos (
        .clk(clk), .reset(reset), .frame_rdy(frame_rdy), .rd_data(rd_data),
        .rd_en(rd_en1), .pix_out(pix1), .de(de1), .hsync(hs1), .vsync(vs1),
        .frame_done(fd1)
    );

    frame_scan_out #(.DATA_WIDTH(DW), .RD_LATENCY(L), .SYNC_POL(1'b0)) u_neg (
        .clk(clk), .reset(reset), .frame_rdy(frame_rdy), .rd_data(rd_data),
        .rd_en(rd_en0), .pix_out(pix0), .de(de0), .hsync(hs0), .vsync(vs0),
        .frame_done(fd0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rd_en;
        logic          fd;
        logic          de;
        logic          hs;
        logic          vs;
        logic [DW-1:0] pix;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mon_cyc = 0;
    int obs_rd = 0, mod_rd = 0;
    int obs_fd = 0, mod_fd = 0;

    bit run_m = 1'b0;
    int pos_m = 0;

    bit            rst_h  [MAXC];
    bit            frdy_h [MAXC];
    bit            rde_h  [MAXC];
    bit            hs_h   [MAXC];
    bit            vs_h   [MAXC];
    logic [DW-1:0] dat_h  [MAXC];

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h",
                     name, mon_cyc, act, exp);
        end
    endtask

    // Advance one clock and update the raster model from last cycle's inputs
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_h[cyc-1]) begin
            run_m = 1'b0;
            pos_m = 0;
        end else if (!run_m) begin
            if (frdy_h[cyc-1]) begin
                run_m = 1'b1;
                pos_m = 0;
            end
        end else if (pos_m == FT - 1 && !frdy_h[cyc-1]) begin
            run_m = 1'b0;
            pos_m = 0;
        end else begin
            pos_m = (pos_m + 1) % FT;
        end
    endtask

    // Drive this cycle's inputs and push the predicted outputs
    task automatic apply(input bit r, input bit f);
        int   line, col;
        bit   clr;
        exp_t e;
        reset     = r;
        frame_rdy = f;
        rd_data   = DW'($urandom);
        rst_h[cyc]  = r;
        frdy_h[cyc] = f;
        dat_h[cyc]  = rd_data;
        line = pos_m / HT;
        col  = pos_m % HT;
        rde_h[cyc] = run_m && col < HA && line < VA;
        hs_h[cyc]  = run_m && col >= HA + HFP && col < HA + HFP + HS;
        vs_h[cyc]  = run_m && line >= VA + VFP && line < VA + VFP + VS;
        e.rd_en = rde_h[cyc];
        e.fd    = rde_h[cyc] && col == HA - 1 && line == VA - 1;
        clr = (cyc < D);
        for (int k = 1; k <= D; k++)
            if (cyc - k >= 0 && rst_h[cyc-k]) clr = 1'b1;
        if (clr) begin
            e.de = 1'b0;
            e.hs = 1'b0;
            e.vs = 1'b0;
        end else begin
            e.de = rde_h[cyc-D];
            e.hs = hs_h[cyc-D];
            e.vs = vs_h[cyc-D];
        end
        e.pix = e.de ? dat_h[cyc-1] : '0;
        if (e.rd_en) mod_rd++;
        if (e.fd) mod_fd++;
        sb_q.push_back(e);
    endtask

    // Monitor: compare both instances against the popped prediction
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            mon_cyc++;
            if (rd_en1 === 1'b1) obs_rd++;
            if (fd1 === 1'b1) obs_fd++;
            chk("rd_en",      DW'(rd_en1), DW'(e.rd_en));
            chk("frame_done", DW'(fd1),    DW'(e.fd));
            chk("de",         DW'(de1),    DW'(e.de));
            chk("hsync",      DW'(hs1),    DW'(e.hs));
            chk("vsync",      DW'(vs1),    DW'(e.vs));
            chk("pix_out",    pix1,        e.pix);
            chk("de_neg",     DW'(de0),    DW'(e.de));
            chk("hsync_neg",  DW'(hs0),    DW'(!e.hs));
            chk("vsync_neg",  DW'(vs0),    DW'(!e.vs));
            chk("pix_neg",    pix0,        e.pix);
            chk("rd_en_neg",  DW'(rd_en0), DW'(e.rd_en));
            chk("fd_neg",     DW'(fd0),    DW'(e.fd));
        end
    end

    initial begin
        bit done;
        rst_h[0]  = 1'b1;
        frdy_h[0] = 1'b0;
        dat_h[0]  = '0;

        // Reset held with frame_rdy high
        repeat (5) begin tick(); apply(1'b1, 1'b1); end

        // Continuous frames
        repeat (3 * FT) begin tick(); apply(1'b0, 1'b1); end

        // Drop frame_rdy at h_cnt=2 of the first line
        done = 1'b0;
        for (int i = 0; i < 4 * FT && !done; i++) begin
            tick();
            if (run_m && pos_m == 2) begin
                apply(1'b0, 1'b0);
                done = 1'b1;
            end else begin
                apply(1'b0, 1'b1);
            end
        end
        if (!done) chk("drop_point_reached", DW'(done), DW'(1'b1));
        repeat (FT + 50) begin tick(); apply(1'b0, 1'b0); end

        // Restart, then reset at v_cnt=1, h_cnt=1
        done = 1'b0;
        for (int i = 0; i < 4 * FT && !done; i++) begin
            tick();
            if (run_m && pos_m == HT + 1) begin
                apply(1'b1, 1'b1);
                done = 1'b1;
            end else begin
                apply(1'b0, 1'b1);
            end
        end
        if (!done) chk("reset_point_reached", DW'(done), DW'(1'b1));
        repeat (2 * FT) begin tick(); apply(1'b0, 1'b1); end

        // Randomized frame_rdy and occasional reset
        repeat (1500) begin
            bit f, r;
            tick();
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 9) > 2);
            apply(r, f);
        end

        repeat (2) @(negedge clk);
        #1;
        chk("rd_en_total",      DW'(obs_rd), DW'(mod_rd));
        chk("frame_done_total", DW'(obs_fd), DW'(mod_fd));
        chk("scoreboard_empty", DW'(sb_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
